// File: rtl/btle_rx_pdu_streamer_if.sv
// Octet stream from the RX PDU streamer towards the link layer.
// The master drives data/valid/last/crc status, the slave returns ready.
interface btle_rx_pdu_streamer_if;
  logic [7:0] pdu_data;
  logic       pdu_valid;
  logic       pdu_ready;
  logic       pdu_last;
  logic       pdu_crc_ok;

  modport master (output pdu_data, pdu_valid, pdu_last, pdu_crc_ok, input pdu_ready);
  modport slave  (input pdu_data, pdu_valid, pdu_last, pdu_crc_ok, output pdu_ready);
endinterface

// File: rtl/btle_rx_pdu_streamer.sv
// Reads a decoded PDU (header + payload) out of the PHY octet memory and
// streams it over a valid/ready byte interface; bad-CRC packets may be dropped.
//
// state | meaning
// IDLE  | waiting for rx_decode_end; bad-CRC packets counted here when dropped
// FETCH | address presented, waiting MEM_RD_LATENCY cycles for memory data
// HOLD  | octet presented with pdu_valid=1 until the link layer takes it
module btle_rx_pdu_streamer #(
  parameter int PDU_ADDR_BIT_WIDTH = 6,
  parameter int MEM_RD_LATENCY     = 1,
  parameter bit DROP_BAD_CRC       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_decode_end,
  input  logic                          rx_crc_ok,
  input  logic [6:0]                    rx_payload_length,
  output logic [PDU_ADDR_BIT_WIDTH-1:0] rx_pdu_octet_mem_addr,
  input  logic [7:0]                    rx_pdu_octet_mem_data,
  btle_rx_pdu_streamer_if.master        pdu,
  output logic                          busy,
  output logic                          overrun,
  output logic [7:0]                    drop_count
);

  localparam int AW = PDU_ADDR_BIT_WIDTH;
  // 2 + 127 is the longest packet the length field can describe
  localparam int N_CAP = (AW >= 8) ? 129 : (1 << AW);
  localparam logic [8:0] N_MAX = 9'(N_CAP);
  localparam logic [1:0] LAT = 2'(MEM_RD_LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic [1:0]      wait_q, wait_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            crc_q, crc_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      drop_q, drop_d;

  logic [8:0]      n_raw;
  logic [8:0]      n_clamp;
  logic [AW-1:0]   last_addr_calc;

  assign n_raw          = {2'b00, rx_payload_length} + 9'd2;
  assign n_clamp        = (n_raw > N_MAX) ? N_MAX : n_raw;
  assign last_addr_calc = AW'(n_clamp - 9'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      wait_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      crc_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    wait_d      = wait_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    crc_d       = crc_q;
    busy_d      = busy_q;
    overrun_d   = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (rx_decode_end) begin
          if (!rx_crc_ok && DROP_BAD_CRC) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            state_d     = FETCH;
            addr_d      = '0;
            last_addr_d = last_addr_calc;
            wait_d      = '0;
            busy_d      = 1'b1;
            crc_d       = rx_crc_ok;
          end
        end
      end
      FETCH: begin
        overrun_d = rx_decode_end;
        if (wait_q == LAT) begin
          data_d  = rx_pdu_octet_mem_data;
          valid_d = 1'b1;
          last_d  = (addr_q == last_addr_q);
          state_d = HOLD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      HOLD: begin
        overrun_d = rx_decode_end;
        if (pdu.pdu_ready) begin
          valid_d = 1'b0;
          wait_d  = '0;
          if (last_q) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_pdu_octet_mem_addr = addr_q;
  assign pdu.pdu_data          = data_q;
  assign pdu.pdu_valid         = valid_q;
  assign pdu.pdu_last          = last_q;
  assign pdu.pdu_crc_ok        = crc_q;
  assign busy                  = busy_q;
  assign overrun               = overrun_q;
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_btle_rx_pdu_streamer.sv
// Scoreboard bench for btle_rx_pdu_streamer: stimulus pushes expected octets
// and first-valid cycles, a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_btle_rx_pdu_streamer;
  localparam int AW = 6;
  localparam int LAT = 1;
  localparam int DEPTH = 64;
  localparam bit DROP = 1'b1;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         crc;
  } oct_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_decode_end = 1'b0;
  logic          rx_crc_ok = 1'b0;
  logic [6:0]    rx_payload_length = '0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          busy;
  logic          overrun;
  logic [7:0]    drop_count;

  btle_rx_pdu_streamer_if pdu_if ();

  btle_rx_pdu_streamer #(
    .PDU_ADDR_BIT_WIDTH(AW),
    .MEM_RD_LATENCY(LAT),
    .DROP_BAD_CRC(DROP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_decode_end(rx_decode_end),
    .rx_crc_ok(rx_crc_ok),
    .rx_payload_length(rx_payload_length),
    .rx_pdu_octet_mem_addr(mem_addr),
    .rx_pdu_octet_mem_data(mem_data),
    .pdu(pdu_if.master),
    .busy(busy),
    .overrun(overrun),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // PHY octet memory with LAT-cycle read pipeline
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data = rd_pipe[LAT-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
  int drop_exp = 0;
  int ovr_exp = 0;
  int ovr_seen = 0;
  oct_t exp_q [$];
  int   rise_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    pdu_if.pdu_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       pdu_if.pdu_ready = 1'($urandom_range(0, 1));
        1:       pdu_if.pdu_ready = 1'b1;
        default: pdu_if.pdu_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet is either dropped, ignored as overrun, or
  // becomes min(2+len, DEPTH) octets read straight from memory in order.
  task automatic issue(input int len, input bit crc, input bit expect_busy);
    int n;
    oct_t e;
    rx_decode_end     = 1'b1;
    rx_crc_ok         = crc;
    rx_payload_length = 7'(len);
    if (expect_busy) begin
      ovr_exp++;
    end else if (!crc && DROP) begin
      if (drop_exp < 255) drop_exp++;
    end else begin
      n = (len + 2 > DEPTH) ? DEPTH : len + 2;
      for (int i = 0; i < n; i++) begin
        e.d    = mem[i];
        e.last = (i == n - 1);
        e.crc  = crc;
        exp_q.push_back(e);
      end
      rise_q.push_back(cyc + 1 + 1 + LAT);
    end
    @(posedge clk);
    #1;
    rx_decode_end = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) return;
    end
    chk({name, "_idle_timeout"}, int'(exp_q.size()), 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  // Monitor
  bit            prev_valid, first_oct = 1, hold_prev, busy_chk;
  int            oct_idx, exp_rise;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic [AW-1:0] hold_addr;

  always @(negedge clk) begin
    oct_t e;
    if (!rst) begin
      prev_valid = 0; first_oct = 1; oct_idx = 0; hold_prev = 0; busy_chk = 0;
    end else begin
      if (overrun) ovr_seen++;
      if (hold_prev) begin
        chk("hold_valid", int'(pdu_if.pdu_valid), 1);
        chk("hold_data", int'(pdu_if.pdu_data), int'(hold_data));
        chk("hold_last", int'(pdu_if.pdu_last), int'(hold_last));
        chk("hold_addr", int'(mem_addr), int'(hold_addr));
      end
      if (busy_chk) begin
        chk("busy_after_last", int'(busy), 0);
        busy_chk = 0;
      end
      if (pdu_if.pdu_valid && !prev_valid) begin
        chk("valid_expected", int'(exp_q.size() != 0), 1);
        if (first_oct) begin
          chk("first_rise_known", int'(rise_q.size() != 0), 1);
          if (rise_q.size() != 0) chk("first_valid_cycle", cyc, rise_q.pop_front());
        end else begin
          chk("next_valid_cycle", cyc, exp_rise);
        end
      end
      if (pdu_if.pdu_valid && pdu_if.pdu_ready) begin
        chk("octet_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("octet_data", int'(pdu_if.pdu_data), int'(e.d));
          chk("octet_last", int'(pdu_if.pdu_last), int'(e.last));
          chk("octet_crc", int'(pdu_if.pdu_crc_ok), int'(e.crc));
          chk("octet_addr", int'(mem_addr), oct_idx);
          if (e.last) begin
            first_oct = 1; oct_idx = 0; busy_chk = 1;
          end else begin
            first_oct = 0; oct_idx++; exp_rise = cyc + 2 + LAT;
          end
        end
      end
      hold_prev  = pdu_if.pdu_valid && !pdu_if.pdu_ready;
      hold_data  = pdu_if.pdu_data;
      hold_last  = pdu_if.pdu_last;
      hold_addr  = mem_addr;
      prev_valid = pdu_if.pdu_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    randomize_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(pdu_if.pdu_data), 0);
    chk("rst_valid", int'(pdu_if.pdu_valid), 0);
    chk("rst_last", int'(pdu_if.pdu_last), 0);
    chk("rst_crc", int'(pdu_if.pdu_crc_ok), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_drop", int'(drop_count), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed packet, always ready
    mem[0] = 8'h02; mem[1] = 8'h04; mem[2] = 8'hA1;
    mem[3] = 8'hB2; mem[4] = 8'hC3; mem[5] = 8'hD4;
    issue(4, 1, 0);
    wait_idle("directed");

    // Backpressure on octet 0xA1
    issue(4, 1, 0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_addr == 2) found = 1;
    end
    chk("bp_reach_addr2", int'(found), 1);
    ready_mode = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pdu_if.pdu_valid) found = 1;
    end
    chk("bp_valid_seen", int'(found), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_data", int'(pdu_if.pdu_data), 8'hA1);
      chk("bp_addr", int'(mem_addr), 2);
      chk("bp_valid", int'(pdu_if.pdu_valid), 1);
    end
    @(posedge clk);
    #1;
    ready_mode = 1;
    wait_idle("backpressure");

    // Three bad-CRC packets are dropped
    for (int i = 0; i < 3; i++) begin
      issue($urandom_range(0, 127), 0, 0);
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drop_three", int'(drop_count), drop_exp);
    chk("drop_no_busy", int'(busy), 0);

    // Overrun while holding an octet
    randomize_mem();
    ready_mode = 2;
    issue(4, 1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (pdu_if.pdu_valid) found = 1;
    end
    chk("ovr_valid_seen", int'(found), 1);
    issue($urandom_range(0, 127), 1, 1);
    chk("ovr_pulse_hi", int'(overrun), 1);
    @(posedge clk);
    #1;
    chk("ovr_pulse_lo", int'(overrun), 0);
    ready_mode = 1;
    wait_idle("overrun");
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_no_second", int'(busy), 0);
    chk("ovr_count", ovr_seen, ovr_exp);

    // Length clamp to memory depth
    randomize_mem();
    ready_mode = 0;
    issue(100, 1, 0);
    wait_idle("clamp");
    ready_mode = 1;

    // Asynchronous reset on the third octet
    randomize_mem();
    issue(10, 1, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pdu_if.pdu_valid && mem_addr == 2) found = 1;
    end
    chk("rstmid_reach", int'(found), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_valid", int'(pdu_if.pdu_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_addr", int'(mem_addr), 0);
    chk("rstmid_last", int'(pdu_if.pdu_last), 0);
    exp_q.delete();
    rise_q.delete();
    drop_exp = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue(5, 1, 0);
    wait_idle("after_reset");

    // drop_count saturation
    for (int i = 0; i < 255; i++) begin
      issue($urandom_range(0, 127), 0, 0);
      @(posedge clk);
      #1;
    end
    chk("drop_255", int'(drop_count), drop_exp);
    issue(3, 0, 0);
    @(posedge clk);
    #1;
    chk("drop_sat", int'(drop_count), drop_exp);

    // Randomized packets with random backpressure and overrun injection
    for (int p = 0; p < 25; p++) begin
      int dly;
      randomize_mem();
      ready_mode = int'($urandom_range(0, 1));
      issue($urandom_range(0, 127), $urandom_range(0, 3) != 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        dly = int'($urandom_range(0, 15));
        for (int k = 0; k < dly; k++) begin
          @(posedge clk);
          #1;
        end
        if (exp_q.size() >= 2) issue($urandom_range(0, 127), 1'($urandom_range(0, 1)), 1);
      end
      wait_idle("random");
    end

    repeat (10) @(posedge clk);
    #1;
    chk("end_exp_q_empty", int'(exp_q.size()), 0);
    chk("end_rise_q_empty", int'(rise_q.size()), 0);
    chk("end_overrun_count", ovr_seen, ovr_exp);
    chk("end_drop_count", int'(drop_count), drop_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
